writeback_stage_ext: RTL and testbench

- Next-generation writeback stage for the 5-stage pipeline.
- Holds the M→W pipeline register with stall, flush and valid tracking.
- Extracts and extends sub-word load data, and selects the register-file write result from four sources.
- Sits between the memory stage and the register file / hazard unit; adds an optional retired-instruction counter.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/load_extend.sv | 43 ++++
 rtl/writeback_stage_ext.sv | 129 ++++++++++++
 tb/tb_writeback_stage_ext.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
// Result-source encoding and RISC-V load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// Sub-word load extraction and sign/zero extension.
// Purely combinational; byte offset width follows the datapath width.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned word_width = 32,
    localparam int unsigned OFF_W     = (word_width == 64) ? 3 : 2
) (
    input  logic [word_width-1:0] i_raw,
    input  logic [OFF_W-1:0]      i_offset,
    input  logic [2:0]            i_funct3,
    output logic [word_width-1:0] o_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_word;

    assign w_byte = i_raw[{i_offset, 3'b000} +: 8];
    assign w_half = i_raw[{i_offset[OFF_W-1:1], 4'b0000} +: 16];

    if (word_width == 64) begin : g_word64
        assign w_word = i_raw[{i_offset[OFF_W-1], 5'b00000} +: 32];
    end else begin : g_word32
        assign w_word = i_raw[31:0];
    end

    // Select the accessed field and widen it according to funct3
    always_comb begin
        o_ext = i_raw;
        case (i_funct3)
            F3_LB:   o_ext = word_width'($signed(w_byte));
            F3_LBU:  o_ext = word_width'(w_byte);
            F3_LH:   o_ext = word_width'($signed(w_half));
            F3_LHU:  o_ext = word_width'(w_half);
            F3_LW:   o_ext = word_width'($signed(w_word));
            F3_LWU:  o_ext = word_width'(w_word);
            F3_LD:   o_ext = i_raw;
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/writeback_stage_ext.sv
// Writeback stage: M->W pipeline register with stall/flush/valid tracking,
// load extraction and four-way result select.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_stage_ext
    import wb_pkg::*;
#(
    parameter int unsigned word_width = 32,
    parameter int unsigned rd_width   = 5,
    parameter int unsigned cnt_width  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  StallW,
    input  logic                  FlushW,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            LoadFunct3M,
    input  logic [word_width-1:0] ALUResultM,
    input  logic [word_width-1:0] ReadDataM,
    input  logic [word_width-1:0] PCPlus4M,
    input  logic [word_width-1:0] ImmExtM,
    input  logic [rd_width-1:0]   RdM,
    output logic [word_width-1:0] ResultW,
    output logic                  RegWriteW,
    output logic [rd_width-1:0]   RdW,
    output logic                  ValidW
`ifdef WB_INSTRET_EN
   ,output logic [cnt_width-1:0]  InstRetW
`endif
);

    localparam int unsigned OFF_W = (word_width == 64) ? 3 : 2;

    if (!(word_width == 32 || word_width == 64)) begin : g_bad_word_width
        $error("writeback_stage_ext: word_width must be 32 or 64");
    end
    if (cnt_width < 1) begin : g_bad_cnt_width
        $error("writeback_stage_ext: cnt_width must be at least 1");
    end

    logic                  r_valid;
    logic                  r_regwrite;
    result_src_t           r_src;
    logic [2:0]            r_funct3;
    logic [word_width-1:0] r_alu;
    logic [word_width-1:0] r_rdata;
    logic [word_width-1:0] r_pc4;
    logic [word_width-1:0] r_imm;
    logic [rd_width-1:0]   r_rd;

    logic [word_width-1:0] w_load;

    // M->W register: flush squashes valid/write, stall holds, else capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_src      <= RES_ALU;
            r_funct3   <= '0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
        end else if (FlushW) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_src      <= result_src_t'(ResultSrcM);
            r_funct3   <= LoadFunct3M;
            r_alu      <= ALUResultM;
            r_rdata    <= ReadDataM;
            r_pc4      <= PCPlus4M;
            r_imm      <= ImmExtM;
            r_rd       <= RdM;
        end else if (!StallW) begin
            r_valid    <= ValidM;
            r_regwrite <= RegWriteM;
            r_src      <= result_src_t'(ResultSrcM);
            r_funct3   <= LoadFunct3M;
            r_alu      <= ALUResultM;
            r_rdata    <= ReadDataM;
            r_pc4      <= PCPlus4M;
            r_imm      <= ImmExtM;
            r_rd       <= RdM;
        end
    end

    load_extend #(
        .word_width (word_width)
    ) u_load_extend (
        .i_raw    (r_rdata),
        .i_offset (r_alu[OFF_W-1:0]),
        .i_funct3 (r_funct3),
        .o_ext    (w_load)
    );

    // Result select, fully decoded over the four sources
    always_comb begin
        ResultW = r_alu;
        case (r_src)
            RES_ALU:  ResultW = r_alu;
            RES_LOAD: ResultW = w_load;
            RES_PC4:  ResultW = r_pc4;
            RES_IMM:  ResultW = r_imm;
            default:  ResultW = r_alu;
        endcase
    end

    assign RegWriteW = r_regwrite & r_valid & (r_rd != '0);
    assign RdW       = r_rd;
    assign ValidW    = r_valid;

`ifdef WB_INSTRET_EN
    logic [cnt_width-1:0] r_instret;

    // Count instructions leaving W; a flush does not cancel the one already in W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
        end else if (r_valid && !StallW) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign InstRetW = r_instret;
`endif

endmodule

// File: tb/tb_writeback_stage_ext.sv
// Directed self-checking bench for writeback_stage_ext (32-bit, cnt_width=8).
module tb_writeback_stage_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadFunct3M;
    logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
    logic [4:0]  RdM;
    logic [31:0] ResultW;
    logic        RegWriteW, ValidW;
    logic [4:0]  RdW;
`ifdef WB_INSTRET_EN
    logic [7:0]  InstRetW;
`endif

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    writeback_stage_ext #(
        .word_width (32),
        .rd_width   (5),
        .cnt_width  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .StallW      (StallW),
        .FlushW      (FlushW),
        .ValidM      (ValidM),
        .RegWriteM   (RegWriteM),
        .ResultSrcM  (ResultSrcM),
        .LoadFunct3M (LoadFunct3M),
        .ALUResultM  (ALUResultM),
        .ReadDataM   (ReadDataM),
        .PCPlus4M    (PCPlus4M),
        .ImmExtM     (ImmExtM),
        .RdM         (RdM),
        .ResultW     (ResultW),
        .RegWriteW   (RegWriteW),
        .RdW         (RdW),
        .ValidW      (ValidW)
`ifdef WB_INSTRET_EN
       ,.InstRetW    (InstRetW)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        StallW = 0; FlushW = 0; ValidM = 0; RegWriteM = 0;
        ResultSrcM = 2'b00; LoadFunct3M = 3'b000;
        ALUResultM = '0; ReadDataM = '0; PCPlus4M = '0; ImmExtM = '0; RdM = '0;
    endtask

    task automatic issue(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] rd);
        ValidM = 1; RegWriteM = 1; ResultSrcM = src; LoadFunct3M = f3;
        ALUResultM = alu; ReadDataM = rdata; RdM = rd;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #2;
        total_cnt++; if (ValidW !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", ValidW); else pass_cnt++;
        total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL reset_regwrite got=%0b exp=0", RegWriteW); else pass_cnt++;
        total_cnt++; if (ResultW !== 32'h0) $display("FAIL reset_result got=%h exp=0", ResultW); else pass_cnt++;
        total_cnt++; if (RdW !== 5'd0) $display("FAIL reset_rd got=%0d exp=0", RdW); else pass_cnt++;
        step();
        reset = 0;
        step();
    endtask

    task automatic test_load_extract();
        issue(2'b01, 3'b000, 32'h0000_1003, 32'h80FF_1234, 5'd3);
        step();
        total_cnt++; if (ResultW !== 32'hFFFF_FF80) $display("FAIL lb_off3 got=%h exp=ffffff80", ResultW); else pass_cnt++;
        total_cnt++; if (ValidW !== 1'b1 || RegWriteW !== 1'b1) $display("FAIL lb_valid_wr got=%0b%0b exp=11", ValidW, RegWriteW); else pass_cnt++;
        issue(2'b01, 3'b100, 32'h0000_1003, 32'h80FF_1234, 5'd3);
        step();
        total_cnt++; if (ResultW !== 32'h0000_0080) $display("FAIL lbu_off3 got=%h exp=00000080", ResultW); else pass_cnt++;
        issue(2'b01, 3'b000, 32'h0000_1000, 32'h80FF_1234, 5'd3);
        step();
        total_cnt++; if (ResultW !== 32'h0000_0034) $display("FAIL lb_off0 got=%h exp=00000034", ResultW); else pass_cnt++;
        issue(2'b01, 3'b000, 32'h0000_1002, 32'h80FF_1234, 5'd3);
        step();
        total_cnt++; if (ResultW !== 32'hFFFF_FFFF) $display("FAIL lb_off2 got=%h exp=ffffffff", ResultW); else pass_cnt++;
        issue(2'b01, 3'b001, 32'h0000_2002, 32'h8001_7FFF, 5'd4);
        step();
        total_cnt++; if (ResultW !== 32'hFFFF_8001) $display("FAIL lh_off2 got=%h exp=ffff8001", ResultW); else pass_cnt++;
        issue(2'b01, 3'b101, 32'h0000_2002, 32'h8001_7FFF, 5'd4);
        step();
        total_cnt++; if (ResultW !== 32'h0000_8001) $display("FAIL lhu_off2 got=%h exp=00008001", ResultW); else pass_cnt++;
        issue(2'b01, 3'b001, 32'h0000_2001, 32'h8001_7FFF, 5'd4);
        step();
        total_cnt++; if (ResultW !== 32'h0000_7FFF) $display("FAIL lh_off1 got=%h exp=00007fff", ResultW); else pass_cnt++;
        issue(2'b01, 3'b010, 32'h0000_2002, 32'h8001_7FFF, 5'd4);
        step();
        total_cnt++; if (ResultW !== 32'h8001_7FFF) $display("FAIL lw got=%h exp=80017fff", ResultW); else pass_cnt++;
        issue(2'b01, 3'b111, 32'h0000_2003, 32'hA5A5_1234, 5'd4);
        step();
        total_cnt++; if (ResultW !== 32'hA5A5_1234) $display("FAIL f3_other got=%h exp=a5a51234", ResultW); else pass_cnt++;
    endtask

    task automatic test_result_mux();
        issue(2'b00, 3'b000, 32'hDEAD_BEEF, 32'h1111_1111, 5'd7);
        PCPlus4M = 32'h0000_0ABC; ImmExtM = 32'h1234_5000;
        step();
        total_cnt++; if (ResultW !== 32'hDEAD_BEEF) $display("FAIL mux_alu got=%h exp=deadbeef", ResultW); else pass_cnt++;
        ResultSrcM = 2'b11;
        step();
        total_cnt++; if (ResultW !== 32'h1234_5000) $display("FAIL mux_imm got=%h exp=12345000", ResultW); else pass_cnt++;
        ResultSrcM = 2'b10;
        step();
        total_cnt++; if (ResultW !== 32'h0000_0ABC) $display("FAIL mux_pc4 got=%h exp=00000abc", ResultW); else pass_cnt++;
    endtask

    task automatic test_x0_suppress();
        issue(2'b00, 3'b000, 32'h5, 32'h0, 5'd0);
        step();
        total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL x0_write got=%0b exp=0", RegWriteW); else pass_cnt++;
        total_cnt++; if (ValidW !== 1'b1) $display("FAIL x0_valid got=%0b exp=1", ValidW); else pass_cnt++;
        RdM = 5'd5;
        step();
        total_cnt++; if (RegWriteW !== 1'b1) $display("FAIL rd5_write got=%0b exp=1", RegWriteW); else pass_cnt++;
        total_cnt++; if (RdW !== 5'd5) $display("FAIL rd5_rd got=%0d exp=5", RdW); else pass_cnt++;
        ValidM = 0;
        step();
        total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL bubble_write got=%0b exp=0", RegWriteW); else pass_cnt++;
        ValidM = 1; RegWriteM = 0;
        step();
        total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL nowrite got=%0b exp=0", RegWriteW); else pass_cnt++;
    endtask

    task automatic test_stall_flush();
        issue(2'b10, 3'b000, 32'h0, 32'h0, 5'd1);
        PCPlus4M = 32'h0000_0104;
        step();
        total_cnt++; if (ResultW !== 32'h0000_0104) $display("FAIL pc4_load got=%h exp=00000104", ResultW); else pass_cnt++;
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            PCPlus4M = 32'h0000_0200 + 32'(i);
            ResultSrcM = 2'b00; ALUResultM = 32'h0BAD_0000 + 32'(i); RdM = 5'd9;
            step();
            total_cnt++; if (ResultW !== 32'h0000_0104) $display("FAIL stall_hold%0d got=%h exp=00000104", i, ResultW); else pass_cnt++;
            total_cnt++; if (RdW !== 5'd1) $display("FAIL stall_rd%0d got=%0d exp=1", i, RdW); else pass_cnt++;
        end
        StallW = 0;
        ResultSrcM = 2'b10; PCPlus4M = 32'h0000_0200;
        step();
        total_cnt++; if (ResultW !== 32'h0000_0200) $display("FAIL stall_release got=%h exp=00000200", ResultW); else pass_cnt++;
        FlushW = 1; StallW = 1;
        step();
        total_cnt++; if (ValidW !== 1'b0) $display("FAIL flush_stall_valid got=%0b exp=0", ValidW); else pass_cnt++;
        total_cnt++; if (RegWriteW !== 1'b0) $display("FAIL flush_stall_write got=%0b exp=0", RegWriteW); else pass_cnt++;
        FlushW = 0;
        step();
        total_cnt++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) $display("FAIL stall_bubble got=%0b%0b exp=00", ValidW, RegWriteW); else pass_cnt++;
        StallW = 0;
        step();
        total_cnt++; if (ValidW !== 1'b1) $display("FAIL after_bubble got=%0b exp=1", ValidW); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        issue(2'b00, 3'b000, 32'h0000_0777, 32'h0, 5'd6);
        step();
        total_cnt++; if (ValidW !== 1'b1) $display("FAIL pre_reset_valid got=%0b exp=1", ValidW); else pass_cnt++;
        #2;
        reset = 1;
        #1;
        total_cnt++; if (ValidW !== 1'b0 || RegWriteW !== 1'b0) $display("FAIL async_reset_vw got=%0b%0b exp=00", ValidW, RegWriteW); else pass_cnt++;
        total_cnt++; if (ResultW !== 32'h0 || RdW !== 5'd0) $display("FAIL async_reset_data got=%h/%0d exp=0/0", ResultW, RdW); else pass_cnt++;
`ifdef WB_INSTRET_EN
        total_cnt++; if (InstRetW !== 8'd0) $display("FAIL async_reset_instret got=%0d exp=0", InstRetW); else pass_cnt++;
`endif
        step();
        reset = 0;
        idle_inputs();
        step();
    endtask

`ifdef WB_INSTRET_EN
    task automatic test_instret();
        idle_inputs();
        reset = 1; step(); reset = 0; step();
        total_cnt++; if (InstRetW !== 8'd0) $display("FAIL instret_start got=%0d exp=0", InstRetW); else pass_cnt++;
        issue(2'b00, 3'b000, 32'h1, 32'h0, 5'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 3) begin
                StallW = 1; step(); step(); StallW = 0;
            end
        end
        ValidM = 0;
        step(); step(); step();
        total_cnt++; if (InstRetW !== 8'd10) $display("FAIL instret_ten got=%0d exp=10", InstRetW); else pass_cnt++;
        reset = 1; step(); reset = 0;
        ValidM = 1;
        for (int i = 0; i < 256; i++) step();
        total_cnt++; if (InstRetW !== 8'hFF) $display("FAIL instret_max got=%h exp=ff", InstRetW); else pass_cnt++;
        step();
        total_cnt++; if (InstRetW !== 8'h00) $display("FAIL instret_wrap got=%h exp=00", InstRetW); else pass_cnt++;
        idle_inputs();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_load_extract();
        test_result_mux();
        test_x0_suppress();
        test_stall_flush();
        test_reset_midstream();
`ifdef WB_INSTRET_EN
        test_instret();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
